inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Program-store instruction loader: holds a host-written program and replays it
// as repeated bursts to the downstream instruction memory, with a fixed idle gap.
module inst_loader #(
  parameter int INST_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int GAP        = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [INST_WIDTH-1:0] host_wdata,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic [7:0]            rep_cnt,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  inst_out_v,
  output logic [INST_WIDTH-1:0] inst_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [GW-1:0]       GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [INST_WIDTH-1:0] rd_q;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [7:0]            reps_q, reps_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  rd_v_q, rd_v_d;
  logic                  out_v_q, out_v_d;
  logic [INST_WIDTH-1:0] out_q, out_d;
  logic                  done_q, done_d;
  logic                  accept;

  // done is registered one cycle behind the DONE state, so busy spans it too
  // and a start landing on the done cycle is refused.
  assign busy       = (state_q != S_IDLE) | done_q;
  assign done       = done_q;
  assign inst_out_v = out_v_q;
  assign inst_out   = out_q;
  assign accept     = (state_q == S_IDLE) && !done_q && start && (prog_len != '0);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          reps_d  = (rep_cnt == 8'd0) ? 8'd1 : rep_cnt;
          addr_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (addr_q == len_q - 1'b1) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          reps_d = reps_q - 8'd1;
          addr_d = '0;
          state_d = (reps_q == 8'd1) ? S_DONE : S_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-stage read pipeline: RAM register, then masked output register.
  always_comb begin
    rd_v_d  = (state_q == S_SEND);
    out_v_d = rd_v_q;
    out_d   = rd_v_q ? rd_q : '0;
    done_d  = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      rd_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      rd_v_q  <= rd_v_d;
      out_v_q <= out_v_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && host_we && !busy) mem[host_addr] <= host_wdata;
    rd_q <= mem[addr_q[ADDR_WIDTH-1:0]];
  end

endmodule
